// File: rtl/div_iter_unit.sv
// Iterative restoring divider (unsigned / signed truncating) for the EX stage.
// Resolves STEPS quotient bits per cycle; results are held until the next accepted start.
module div_iter_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             signed_div_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CYCLES = WIDTH / STEPS;
    localparam int unsigned CNT_W  = $clog2(CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             neg1_q, neg2_q, dz_q;
    logic [WIDTH-1:0] quo_q, dvs_q;
    logic [WIDTH:0]   rem_q;

    logic             accept, last_step, op2_zero;
    logic             neg1, neg2;
    logic [WIDTH-1:0] abs1, abs2;

    assign accept    = (state_q == StIdle) && start_i && !annul_i;
    assign last_step = (cnt_q == CNT_W'(CYCLES - 1));
    assign op2_zero  = (opdata2_i == '0);

    // Sign flags already include the signed mode, so unsigned ops never negate.
    assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
    assign neg2 = signed_div_i & opdata2_i[WIDTH-1];
    assign abs1 = neg1 ? -opdata1_i : opdata1_i;
    assign abs2 = neg2 ? -opdata2_i : opdata2_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = op2_zero ? StFix : StBusy;
            StBusy: begin
                if (annul_i) begin
                    state_d = StIdle;
                end else if (last_step) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = annul_i ? StIdle : StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Dividend shifts out of quo_q while quotient bits shift in; the borrow of the
    // WIDTH+1-bit trial subtract picks restore vs keep.
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH:0]   rem_nx, rem_sh, diff;

    always_comb begin
        quo_nx = quo_q;
        rem_nx = rem_q;
        rem_sh = '0;
        diff   = '0;
        for (int i = 0; i < int'(STEPS); i++) begin
            rem_sh = {rem_nx[WIDTH-1:0], quo_nx[WIDTH-1]};
            diff   = rem_sh - {1'b0, dvs_q};
            quo_nx = {quo_nx[WIDTH-2:0], ~diff[WIDTH]};
            rem_nx = diff[WIDTH] ? rem_sh : diff;
        end
    end

    // On a zero divisor rem_q holds |op1|, so the dividend-sign fix restores the original.
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign quo_fix = ((neg1_q ^ neg2_q) && !dz_q) ? -quo_q : quo_q;
    assign rem_fix = neg1_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
            dz_q        <= 1'b0;
            quo_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else begin
            if (accept) begin
                neg1_q <= neg1;
                neg2_q <= neg2;
                dz_q   <= op2_zero;
                dvs_q  <= abs2;
                cnt_q  <= '0;
                if (op2_zero) begin
                    quo_q <= '1;
                    rem_q <= {1'b0, abs1};
                end else begin
                    quo_q <= abs1;
                    rem_q <= '0;
                end
            end else if (state_q == StBusy) begin
                quo_q <= quo_nx;
                rem_q <= rem_nx;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == StFix && !annul_i) begin
                quotient_o  <= quo_fix;
                remainder_o <= rem_fix;
                div_zero_o  <= dz_q;
            end
        end
    end

    assign busy_o  = (state_q == StBusy) || (state_q == StFix);
    assign ready_o = (state_q == StDone);

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: STEPS=1 and STEPS=4 instances sharing clock and reset,
// with a result scoreboard per instance.
module tb_div_iter_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_start, a_annul, a_sgn, a_busy, a_ready, a_dz;
    logic [31:0] a_op1, a_op2, a_q, a_r;
    logic        b_start, b_annul, b_sgn, b_busy, b_ready, b_dz;
    logic [31:0] b_op1, b_op2, b_q, b_r;

    div_iter_unit #(.WIDTH(32), .STEPS(1)) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .annul_i(a_annul), .signed_div_i(a_sgn),
        .opdata1_i(a_op1), .opdata2_i(a_op2), .busy_o(a_busy), .ready_o(a_ready),
        .div_zero_o(a_dz), .quotient_o(a_q), .remainder_o(a_r)
    );

    div_iter_unit #(.WIDTH(32), .STEPS(4)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .annul_i(b_annul), .signed_div_i(b_sgn),
        .opdata1_i(b_op1), .opdata2_i(b_op2), .busy_o(b_busy), .ready_o(b_ready),
        .div_zero_o(b_dz), .quotient_o(b_q), .remainder_o(b_r)
    );

    typedef struct packed {
        logic        sgn;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   a_rdy_cnt = 0;
    int   b_rdy_cnt = 0;
    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any ready pulse against the queues.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (a_ready) begin
            a_rdy_cnt++;
            if (exp_a.size() == 0) begin
                chk("a_spurious_ready", 32'(a_ready), 32'd0);
            end else begin
                e = exp_a.pop_front();
                chk("a_quotient", a_q, e.q);
                chk("a_remainder", a_r, e.r);
                chk("a_div_zero", 32'(a_dz), 32'(e.dz));
            end
        end
        if (b_ready) begin
            b_rdy_cnt++;
            if (exp_b.size() == 0) begin
                chk("b_spurious_ready", 32'(b_ready), 32'd0);
            end else begin
                e = exp_b.pop_front();
                chk("b_quotient", b_q, e.q);
                chk("b_remainder", b_r, e.r);
                chk("b_div_zero", 32'(b_dz), 32'(e.dz));
            end
        end
    endtask

    task automatic drive(input bit on_b, input logic st, input logic sgn,
                         input logic [31:0] x, input logic [31:0] y);
        if (on_b) begin
            b_start = st; b_sgn = sgn; b_op1 = x; b_op2 = y;
        end else begin
            a_start = st; a_sgn = sgn; a_op1 = x; a_op2 = y;
        end
    endtask

    // One full operation; poke>0 re-asserts start with other operands at that busy cycle.
    task automatic op(input string nm, input bit on_b, input logic sgn,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eq, input logic [31:0] er, input logic edz,
                      input int poke);
        int lat, busy_n, rc, exp_lat;
        exp_t e;
        exp_lat = edz ? 2 : (on_b ? 10 : 34);
        e = '{q: eq, r: er, dz: edz};
        if (on_b) exp_b.push_back(e);
        else exp_a.push_back(e);
        drive(on_b, 1'b1, sgn, x, y);
        rc = on_b ? b_rdy_cnt : a_rdy_cnt;
        busy_n = 0;
        for (lat = 1; lat <= 100; lat++) begin
            step();
            if (lat == 1) drive(on_b, 1'b0, ~sgn, ~x, ~y);
            if (poke > 0 && lat == poke) drive(on_b, 1'b1, sgn, 32'd99, 32'd1);
            if (poke > 0 && lat == poke + 1) drive(on_b, 1'b0, sgn, 32'd0, 32'd0);
            if ((on_b ? b_rdy_cnt : a_rdy_cnt) != rc) break;
            if (on_b ? b_busy : a_busy) busy_n++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat - 1));
        chk({nm, "_busy_at_ready"}, 32'(on_b ? b_busy : a_busy), 32'd0);
    endtask

    initial begin
        int rc;
        rst = 1'b1;
        a_annul = 1'b0;
        b_annul = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        vecs[0]  = '{1'b0, 32'd7,        32'd2,        32'd3,        32'd1,        1'b0};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
        vecs[3]  = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0};
        vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
        vecs[5]  = '{1'b0, 32'h12345678, 32'd0,        32'hFFFFFFFF, 32'h12345678, 1'b1};
        vecs[6]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1};
        vecs[8]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
        vecs[9]  = '{1'b0, 32'd5,        32'd9,        32'd0,        32'd5,        1'b0};
        vecs[10] = '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0};
        vecs[11] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};

        repeat (2) @(negedge clk);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_a_dz", 32'(a_dz), 32'd0);
        chk("rst_a_q", a_q, 32'd0);
        chk("rst_a_r", a_r, 32'd0);
        chk("rst_b_q", b_q, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            op($sformatf("vec%0d", i), 1'b0, vecs[i].sgn, vecs[i].op1, vecs[i].op2,
               vecs[i].q, vecs[i].r, vecs[i].dz, 0);
            step();
        end

        // Annul at busy cycle 10: no ready, idle next cycle, previous result kept.
        rc = a_rdy_cnt;
        drive(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (9) step();
        chk("annul_busy_before", 32'(a_busy), 32'd1);
        a_annul = 1'b1;
        step();
        a_annul = 1'b0;
        chk("annul_idle_next", 32'(a_busy), 32'd0);
        repeat (40) step();
        chk("annul_no_ready", 32'(a_rdy_cnt - rc), 32'd0);
        chk("annul_q_kept", a_q, 32'd1);
        chk("annul_r_kept", a_r, 32'd0);

        // Start during BUSY is ignored.
        op("poke", 1'b0, 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 5);

        // Start in the ready cycle is ignored; held into the next (idle) cycle it is accepted.
        drive(1'b0, 1'b1, 1'b0, 32'd50, 32'd5);
        step();
        chk("done_start_ignored", 32'(a_busy), 32'd0);
        op("b2b", 1'b0, 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 0);

        // Start together with annul in idle is not accepted.
        drive(1'b0, 1'b1, 1'b0, 32'd9, 32'd3);
        a_annul = 1'b1;
        step();
        chk("start_annul_idle", 32'(a_busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        a_annul = 1'b0;
        step();
        chk("start_annul_idle2", 32'(a_busy), 32'd0);
        repeat (40) step();

        // STEPS=4 instance.
        op("s4_umax", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 1'b0, 0);
        step();
        op("s4_neg", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0);
        step();

        // Asynchronous reset mid-BUSY clears outputs before any clock edge.
        drive(1'b1, 1'b1, 1'b0, 32'd1000, 32'd3);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) step();
        chk("b_busy_before_rst", 32'(b_busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_b_q", b_q, 32'd0);
        chk("arst_b_r", b_r, 32'd0);
        chk("arst_b_busy", 32'(b_busy), 32'd0);
        chk("arst_b_ready", 32'(b_ready), 32'd0);
        chk("arst_a_q", a_q, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        op("s4_after_rst", 1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);
        repeat (3) step();

        chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
        chk("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
